serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Parametrised multi-cycle adder/subtractor. It is the sequential successor of the 1-bit full-adder cell.
//  Adds or subtracts two WIDTH-bit operands DIGIT bits per clock through a DIGIT-bit ripple slice,
//  with carry/borrow and signed-overflow flags. Uses a valid/ready handshake on both input and output.
//  Sits between operand producers and result consumers where area matters more than latency.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; >= 1
//  DIGIT  1  bits processed per cycle; 1..WIDTH, WIDTH % DIGIT == 0 (elaboration error otherwise)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous reset, active-low
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: a+b+cin; 1: a-b-cin
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result
//  sum        out  WIDTH  result mod 2^WIDTH
//  cout       out  1      add: carry-out; sub: borrow-out (1 = a < b+cin unsigned)
//  ovf        out  1      signed overflow (carry into MSB ^ carry out of MSB)
// BEHAVIOUR
//  Reset (rst_n low at clk edge): state IDLE. in_ready=1 after reset. out_valid=0. sum=0, cout=0, ovf=0.
//   Any in-flight operation is discarded. Reset has priority over all handshakes.
//  STEPS = WIDTH/DIGIT. FSM states IDLE -> RUN -> DONE.
//  IDLE: in_ready=1. On in_valid&in_ready the block latches a and bx = sub ? ~b : b.
//   Carry register c = sub ? ~cin : cin; sub flag is latched; step counter = 0. Go to RUN.
//  RUN: in_ready=0. Each cycle the slice adds the DIGIT LSBs of a, bx and c.
//   The slice digit is shifted into the MSB end of the result shift register; a and bx shift right by DIGIT.
//   The carry register is updated. After STEPS RUN cycles go to DONE.
//  Latency: accept at edge N -> out_valid=1 after edge N+STEPS+1. DIGIT=WIDTH gives 2 cycles.
//  DONE: out_valid=1. sum/cout/ovf hold stable until out_valid&out_ready.
//   cout = sub ? ~c_final : c_final. ovf = carry-in of final MSB bit ^ c_final.
//  Simultaneous: in DONE, in_ready = out_ready. A new accept coinciding with the output handshake
//   goes straight to RUN, giving zero-bubble back-to-back operation. Output handshake without new input -> IDLE.
//  Outputs sum/cout/ovf keep their last value after the handshake; consumers sample only when out_valid=1.
//  Operand inputs are sampled only on the accept edge; changes at other times are ignored.
//  Counter width is $clog2(STEPS+1); the counter never wraps, because STEPS is terminal.
// STRUCTURE
//  Shared package serial_adder_pkg: state enum {IDLE, RUN, DONE}.
//   Also holds the function steps(WIDTH, DIGIT) and the localparam check helper.
//  One sub-module: digit_adder #(DIGIT): combinational ripple of DIGIT full adders.
//   Ports a, b, cin -> sum, cout, c_msb_in (carry into top bit, used for ovf).
//  Top holds the FSM, counter, shift registers and flag registers.
// TESTING
//  W8/D1: a=8'hFF b=8'h01 cin=0 sub=0 -> sum=8'h00 cout=1 ovf=0, out_valid exactly 9 edges after accept.
//  W8/D1: a=8'h7F b=8'h01 add -> sum=8'h80 cout=0 ovf=1.
//   Sub: a=8'h10 b=8'h20 cin=0 -> sum=8'hF0 cout=1 ovf=0.
//  Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum/cout/ovf stable, in_ready=0.
//   Then assert out_ready and in_valid in the same cycle -> new op accepted, next result after STEPS+1.
//  Reset mid-op: drop rst_n at RUN step 4 -> next edge out_valid=0, in_ready=1.
//   A following op a=3 b=4 yields sum=7 with no residue.
//  Exhaustive W4 with D1, D2, D4: all a, b, cin, sub -> match reference model (a±b±cin); latency = STEPS+1.
//  Randomised W16/D4 with random valid/ready stalls: scoreboard order and values, no drops or duplicates.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int unsigned steps(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned digit);
        return (width >= 1) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into its top bit.
module digit_adder #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb_in
);

    always_comb begin
        logic [DIGIT:0] w_carry;
        w_carry    = '0;
        w_carry[0] = i_cin;
        o_sum      = '0;
        for (int i = 0; i < DIGIT; i++) begin
            o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
            w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
        end
        o_cout     = w_carry[DIGIT];
        o_c_msb_in = w_carry[DIGIT-1];
    end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a ripple slice,
// valid/ready handshake on both sides, carry/borrow and signed-overflow flags.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int unsigned STEPS = steps(WIDTH, DIGIT);
    localparam int unsigned CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS);
    localparam logic [CNT_W-1:0] CNT_FINAL_STEP = CNT_W'(STEPS - 1);

    if (!params_ok(WIDTH, DIGIT)) begin : g_param_err
        $error("serial_adder: DIGIT must lie in 1..WIDTH and divide WIDTH");
    end

    state_e             r_state;
    state_e             w_state_d;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_bx;
    logic [WIDTH-1:0]   r_sum;
    logic               r_c;
    logic               r_sub;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_cout;
    logic               r_ovf;

    logic [DIGIT-1:0]       w_dsum;
    logic                   w_dcout;
    logic                   w_dcmsb;
    logic                   w_accept;
    logic                   w_step;
    logic [WIDTH+DIGIT-1:0] w_sum_cat;
    logic [WIDTH-1:0]       w_sum_next;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .i_a        (r_a[DIGIT-1:0]),
        .i_b        (r_bx[DIGIT-1:0]),
        .i_cin      (r_c),
        .o_sum      (w_dsum),
        .o_cout     (w_dcout),
        .o_c_msb_in (w_dcmsb)
    );

    // New digit enters at the MSB end; after STEPS shifts the LSB digit sits at bit 0.
    assign w_sum_cat  = {w_dsum, r_sum};
    assign w_sum_next = w_sum_cat[WIDTH+DIGIT-1:DIGIT];

    always_comb begin
        w_state_d   = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_state_d = RUN;
                end
            end
            RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                o_out_valid = 1'b1;
                o_in_ready  = i_out_ready;
                if (i_out_ready) begin
                    w_state_d = i_in_valid ? RUN : IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    assign w_accept = i_in_valid & o_in_ready;
    assign w_step   = (r_state == RUN) && (r_cnt != CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_bx    <= '0;
            r_sum   <= '0;
            r_c     <= 1'b0;
            r_sub   <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                // Subtraction runs as a + ~b + ~borrow_in.
                r_a   <= i_a;
                r_bx  <= i_sub ? ~i_b : i_b;
                r_c   <= i_sub ? ~i_cin : i_cin;
                r_sub <= i_sub;
                r_cnt <= '0;
            end else if (w_step) begin
                r_a   <= r_a >> DIGIT;
                r_bx  <= r_bx >> DIGIT;
                r_sum <= w_sum_next;
                r_c   <= w_dcout;
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_FINAL_STEP) begin
                    r_cout <= r_sub ? ~w_dcout : w_dcout;
                    r_ovf  <= w_dcmsb ^ w_dcout;
                end
            end
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed W8/D1 cases, exhaustive W4 (D1/D2/D4), random W16/D4 with stalls.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    // W8 / D1
    logic       s8_in_valid, s8_in_ready, s8_out_valid, s8_out_ready;
    logic [7:0] s8_a, s8_b, s8_sum;
    logic       s8_cin, s8_sub, s8_cout, s8_ovf;
    logic [17:0] q8[$];

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(s8_in_valid), .o_in_ready(s8_in_ready),
        .i_a(s8_a), .i_b(s8_b), .i_cin(s8_cin), .i_sub(s8_sub), .o_out_valid(s8_out_valid),
        .i_out_ready(s8_out_ready), .o_sum(s8_sum), .o_cout(s8_cout), .o_ovf(s8_ovf)
    );

    // W4 with D = 1, 2, 4 sharing operands
    logic [2:0] w4_in_valid, w4_in_ready, w4_out_valid, w4_cout, w4_ovf;
    logic [3:0] w4_sum [3];
    logic [3:0] w4_a, w4_b;
    logic       w4_cin, w4_sub, w4_out_ready;

    for (genvar g = 0; g < 3; g++) begin : g_w4
        serial_adder #(.WIDTH(4), .DIGIT(1 << g)) u_dut (
            .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(w4_in_valid[g]),
            .o_in_ready(w4_in_ready[g]), .i_a(w4_a), .i_b(w4_b), .i_cin(w4_cin),
            .i_sub(w4_sub), .o_out_valid(w4_out_valid[g]), .i_out_ready(w4_out_ready),
            .o_sum(w4_sum[g]), .o_cout(w4_cout[g]), .o_ovf(w4_ovf[g])
        );
    end

    // W16 / D4
    logic        t_in_valid, t_in_ready, t_out_valid, t_out_ready;
    logic [15:0] t_a, t_b, t_sum;
    logic        t_cin, t_sub, t_cout, t_ovf;
    logic [17:0] q16[$];

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_w16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(t_in_valid), .o_in_ready(t_in_ready),
        .i_a(t_a), .i_b(t_b), .i_cin(t_cin), .i_sub(t_sub), .o_out_valid(t_out_valid),
        .i_out_ready(t_out_ready), .o_sum(t_sum), .o_cout(t_cout), .o_ovf(t_ovf)
    );

    // Reference: returns {ovf, cout, sum[15:0]} for a w-bit a +/- b +/- cin.
    function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        longint m, ua, ub, sa, sb, uc, full, sres;
        logic   co, ov;
        logic [15:0] s;
        m  = longint'(1) << w;
        ua = longint'(a);
        ub = longint'(b);
        uc = cin ? 64'sd1 : 64'sd0;
        sa = a[w-1] ? ua - m : ua;
        sb = b[w-1] ? ub - m : ub;
        if (!sub) begin
            full = ua + ub + uc;
            co   = (full >= m);
            sres = sa + sb + uc;
        end else begin
            full = ua - ub - uc;
            co   = (ua < ub + uc);
            sres = sa - sb - uc;
        end
        s  = 16'(full & (m - 1));
        ov = (sres < -(m / 2)) || (sres >= m / 2);
        return {ov, co, s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, input logic [17:0] exp);
        s8_a = a; s8_b = b; s8_cin = cin; s8_sub = sub; s8_in_valid = 1'b1;
        #1;
        chk("w8_accept_ready", 32'(s8_in_ready), 32'd1);
        @(posedge clk);
        q8.push_back(exp);
        #1;
        s8_in_valid = 1'b0;
    endtask

    task automatic recv8(input string tag, input int exp_lat);
        int lat;
        logic [17:0] e;
        lat = 0;
        while (!s8_out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_queue"}, 32'(q8.size() > 0), 32'd1);
        e = (q8.size() > 0) ? q8.pop_front() : 18'h3ffff;
        chk({tag, "_result"}, 32'({s8_ovf, s8_cout, 8'h00, s8_sum}), 32'(e));
        if (s8_out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [17:0] hold, e4, e;
        logic [2:0]  seen;
        bit          pres;
        int          sent, got, cyc;

        rst_n = 1'b0;
        s8_in_valid = 0; s8_out_ready = 1; s8_a = 0; s8_b = 0; s8_cin = 0; s8_sub = 0;
        w4_in_valid = '0; w4_out_ready = 1; w4_a = 0; w4_b = 0; w4_cin = 0; w4_sub = 0;
        t_in_valid = 0; t_out_ready = 1; t_a = 0; t_b = 0; t_cin = 0; t_sub = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(s8_in_ready), 32'd1);
        chk("rst_out_valid", 32'(s8_out_valid), 32'd0);
        chk("rst_sum", 32'(s8_sum), 32'd0);
        chk("rst_cout", 32'(s8_cout), 32'd0);
        chk("rst_ovf", 32'(s8_ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed W8/D1
        send8(8'hFF, 8'h01, 1'b0, 1'b0, 18'h10000);
        recv8("ff_plus_1", 9);
        send8(8'h7F, 8'h01, 1'b0, 1'b0, 18'h20080);
        recv8("7f_plus_1", 9);
        send8(8'h10, 8'h20, 1'b0, 1'b0 | 1'b1, 18'h100F0);
        recv8("10_minus_20", 9);
        send8(8'h5A, 8'h3C, 1'b1, 1'b1, model(8, 16'h5A, 16'h3C, 1'b1, 1'b1));
        recv8("sub_borrow_in", 9);

        // Backpressure then zero-bubble back-to-back
        s8_out_ready = 1'b0;
        send8(8'h35, 8'h0A, 1'b0, 1'b0, 18'h0003F);
        recv8("bp_first", 9);
        hold = {s8_ovf, s8_cout, 8'h00, s8_sum};
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_hold", 32'({s8_ovf, s8_cout, 8'h00, s8_sum}), 32'(hold));
            chk("bp_in_ready", 32'(s8_in_ready), 32'd0);
            chk("bp_out_valid", 32'(s8_out_valid), 32'd1);
        end
        s8_out_ready = 1'b1;
        send8(8'h80, 8'h80, 1'b0, 1'b0, 18'h30000);
        chk("b2b_running", 32'(s8_out_valid), 32'd0);
        recv8("bp_b2b", 9);

        // Reset in the middle of a run
        s8_a = 8'h55; s8_b = 8'h22; s8_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s8_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 32'(s8_out_valid), 32'd0);
        chk("midrst_in_ready", 32'(s8_in_ready), 32'd1);
        chk("midrst_sum", 32'(s8_sum), 32'd0);
        rst_n = 1'b1;
        send8(8'h03, 8'h04, 1'b0, 1'b0, 18'h00007);
        recv8("after_reset", 9);

        // Exhaustive W4, all three digit widths in lockstep
        for (int v = 0; v < 1024; v++) begin
            w4_a = v[3:0]; w4_b = v[7:4]; w4_cin = v[8]; w4_sub = v[9];
            e4 = model(4, 16'(w4_a), 16'(w4_b), w4_cin, w4_sub);
            w4_in_valid = 3'b111;
            #1;
            if (v == 0) chk("w4_ready", 32'(w4_in_ready), 32'd7);
            @(posedge clk);
            #1;
            w4_in_valid = 3'b000;
            seen = 3'b000;
            for (int c = 1; c <= 7; c++) begin
                @(posedge clk);
                #1;
                for (int k = 0; k < 3; k++) begin
                    if (w4_out_valid[k] && !seen[k]) begin
                        seen[k] = 1'b1;
                        chk($sformatf("w4_d%0d_v%0h", 1 << k, v),
                            32'({c[7:0], w4_ovf[k], w4_cout[k], w4_sum[k]}),
                            32'({8'((4 >> k) + 1), e4[17], e4[16], e4[3:0]}));
                    end
                end
            end
            chk($sformatf("w4_all_done_v%0h", v), 32'(seen), 32'd7);
        end

        // Random W16/D4 with valid/ready stalls
        pres = 0; sent = 0; got = 0; cyc = 0;
        while (got < 60 && cyc < 20000) begin
            if (!pres && sent < 60 && $urandom_range(0, 2) != 0) begin
                pres = 1;
                t_a = 16'($urandom); t_b = 16'($urandom);
                t_cin = 1'($urandom); t_sub = 1'($urandom);
            end
            t_in_valid  = pres;
            t_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (t_out_valid && t_out_ready) begin
                chk("w16_nonempty", 32'(q16.size() > 0), 32'd1);
                e = (q16.size() > 0) ? q16.pop_front() : 18'h3ffff;
                chk($sformatf("w16_result_%0d", got), 32'({t_ovf, t_cout, t_sum}), 32'(e));
                got++;
            end
            if (t_in_valid && t_in_ready) begin
                q16.push_back(model(16, t_a, t_b, t_cin, t_sub));
                sent++;
                pres = 0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        t_in_valid = 1'b0;
        chk("w16_count", 32'(got), 32'd60);
        chk("w16_drained", 32'(q16.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
